// File: rtl/nibble_serial_adder_ctrl_if.sv
// Valid/ready bundle between the PE accumulation logic (master) and nibble_serial_adder_ctrl (slave).
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer around one 4-bit carry-lookahead adder (carryLookAheadAdder4bit logic).
// Optional signed-overflow flag enabled by defining NIBBLE_SERIAL_OVF_EN; otherwise ovf is tied low.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input logic                       clk,
    input logic                       rst,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int               N        = WIDTH / 4;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_nxt;
    logic [WIDTH-1:0] sum_r;
    logic             carry_reg;
    logic             cout_r;
    logic [CNT_W-1:0] idx;
    logic             accept;
    logic             last_step;

    logic [3:0]       cla_a;
    logic [3:0]       cla_b;
    logic [3:0]       cla_p;
    logic [3:0]       cla_g;
    logic [4:0]       cla_c;
    logic [3:0]       cla_sum;

    // Shared 4-bit carry-lookahead adder: every carry is a flat function of g/p and c0.
    assign cla_a    = sa[3:0];
    assign cla_b    = sb[3:0];
    assign cla_p    = cla_a ^ cla_b;
    assign cla_g    = cla_a & cla_b;
    assign cla_c[0] = carry_reg;
    assign cla_c[1] = cla_g[0] | (cla_p[0] & cla_c[0]);
    assign cla_c[2] = cla_g[1] | (cla_p[1] & cla_g[0]) | (cla_p[1] & cla_p[0] & cla_c[0]);
    assign cla_c[3] = cla_g[2] | (cla_p[2] & cla_g[1]) | (cla_p[2] & cla_p[1] & cla_g[0])
                    | (cla_p[2] & cla_p[1] & cla_p[0] & cla_c[0]);
    assign cla_c[4] = cla_g[3] | (cla_p[3] & cla_g[2]) | (cla_p[3] & cla_p[2] & cla_g[1])
                    | (cla_p[3] & cla_p[2] & cla_p[1] & cla_g[0])
                    | (cla_p[3] & cla_p[2] & cla_p[1] & cla_p[0] & cla_c[0]);
    assign cla_sum  = cla_p ^ cla_c[3:0];

    generate
        if (WIDTH == 4) begin : g_single_nibble
            assign result_nxt = cla_sum;
        end else begin : g_multi_nibble
            assign result_nxt = {cla_sum, result[WIDTH-1:4]};
        end
    endgenerate

    assign accept    = (state == IDLE) && bus.in_valid;
    assign last_step = (state == RUN) && (idx == LAST_IDX);

    // NOTE: sequential state uses <= so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no branch leaves state_nxt unassigned and infers a latch.
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = bus.in_valid ? RUN : IDLE;
            RUN: begin
                if (idx > LAST_IDX) begin
                    state_nxt = IDLE;
                end else if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RUN;
                end
            end
            DONE:    state_nxt = bus.out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE:    bus.in_ready  = 1'b1;
            RUN:     bus.busy      = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: bus.in_ready  = 1'b0;
        endcase
    end

    // NOTE: the operand/result shift registers are cleared by reset too, so nothing powers up as X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa        <= '0;
            sb        <= '0;
            result    <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum_r     <= '0;
            cout_r    <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
            sa        <= bus.op_a;
            sb        <= bus.op_sub ? ~bus.op_b : bus.op_b;
            carry_reg <= bus.op_sub;
            idx       <= '0;
        end else if (state == RUN) begin
            sa        <= sa >> 4;
            sb        <= sb >> 4;
            result    <= result_nxt;
            carry_reg <= cla_c[4];
            idx       <= last_step ? '0 : idx + CNT_W'(1);
            if (last_step) begin
                sum_r  <= result_nxt;
                cout_r <= cla_c[4];
            end
        end
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

`ifdef NIBBLE_SERIAL_OVF_EN
    logic ovf_r;
    logic carry_in3;

    // Carry into the sign bit, recovered from the top bit of the final nibble.
    assign carry_in3 = cla_a[3] ^ cla_b[3] ^ cla_sum[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (last_step) begin
            ovf_r <= carry_in3 ^ cla_c[4];
        end
    end

    assign bus.ovf = ovf_r;
`else
    assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: directed cases plus random operations against an arithmetic model.
module tb_nibble_serial_adder_ctrl;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;
    localparam int LIMIT = 50;

    typedef struct packed {
        logic             ovf;
        logic             cout;
        logic [WIDTH-1:0] sum;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        res_t r;
        int   ua   = int'(a);
        int   ub   = int'(b);
        int   sa   = int'($signed(a));
        int   sb   = int'($signed(b));
        int   ures = sub ? ua - ub : ua + ub;
        int   sres = sub ? sa - sb : sa + sb;
        r.sum  = WIDTH'(ures);
        r.cout = sub ? (ua >= ub) : (ures >= (1 << WIDTH));
`ifdef NIBBLE_SERIAL_OVF_EN
        r.ovf  = (sres > (1 << (WIDTH - 1)) - 1) || (sres < -(1 << (WIDTH - 1)));
`else
        r.ovf  = 1'b0;
`endif
        return r;
    endfunction

    // Presents an operation and returns #1 after the edge that accepted it.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_sub   = sub;
        while (bus.in_ready !== 1'b1 && waited < LIMIT) begin
            @(posedge clk); #1;
            waited++;
        end
        check("accept_wait_bounded", 32'(waited < LIMIT), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op_a     = WIDTH'($urandom);
        bus.op_b     = WIDTH'($urandom);
        bus.op_sub   = 1'($urandom);
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (bus.out_valid !== 1'b1 && edges < LIMIT) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub, input int hold);
        res_t exp = model(a, b, sub);
        int   edges;
        send(a, b, sub);
        check("run_busy", 32'(bus.busy), 32'd1);
        check("run_in_ready", 32'(bus.in_ready), 32'd0);
        wait_done(edges);
        check("latency_edges", 32'(edges), 32'(N));
        check("result_sum", 32'(bus.sum), 32'(exp.sum));
        check("result_cout", 32'(bus.cout), 32'(exp.cout));
        check("result_ovf", 32'(bus.ovf), 32'(exp.ovf));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_sum", 32'(bus.sum), 32'(exp.sum));
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
        end
        release_result();
    endtask

    initial begin
        int   busy_cycles;
        int   first_valid;
        res_t exp;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rs;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_sum", 32'(bus.sum), 32'd0);
        check("reset_cout", 32'(bus.cout), 32'd0);
        check("reset_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;

        // Basic add with out_ready already high: busy spans N RUN cycles plus one DONE cycle.
        bus.out_ready = 1'b1;
        send(16'h1234, 16'h4321, 1'b0);
        busy_cycles = 0;
        first_valid = -1;
        while (bus.busy === 1'b1 && busy_cycles < LIMIT) begin
            if (bus.out_valid === 1'b1 && first_valid < 0) first_valid = busy_cycles;
            busy_cycles++;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        check("basic_busy_cycles", 32'(busy_cycles), 32'(N + 1));
        check("basic_valid_edge", 32'(first_valid), 32'(N));
        check("basic_sum", 32'(bus.sum), 32'h5555);
        check("basic_cout", 32'(bus.cout), 32'd0);
        check("basic_idle_in_ready", 32'(bus.in_ready), 32'd1);

        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        check("ripple_sum", 32'(bus.sum), 32'h0000);
        check("ripple_cout", 32'(bus.cout), 32'd1);
        check("ripple_ovf", 32'(bus.ovf), 32'd0);

        run_op(16'h0005, 16'h0007, 1'b1, 1);
        check("sub_borrow_sum", 32'(bus.sum), 32'hFFFE);
        check("sub_borrow_cout", 32'(bus.cout), 32'd0);

        run_op(16'h0007, 16'h0005, 1'b1, 0);
        check("sub_pos_sum", 32'(bus.sum), 32'h0002);
        check("sub_pos_cout", 32'(bus.cout), 32'd1);

        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        check("ovf_sum", 32'(bus.sum), 32'h8000);
        check("ovf_cout", 32'(bus.cout), 32'd0);
`ifdef NIBBLE_SERIAL_OVF_EN
        check("ovf_flag", 32'(bus.ovf), 32'd1);
`else
        check("ovf_flag", 32'(bus.ovf), 32'd0);
`endif

        run_op(16'h8000, 16'h0001, 1'b1, 0);

        // Backpressure: result stays put for 10 stalled cycles, a new request is ignored meanwhile.
        exp = model(16'h3C5A, 16'h0FF0, 1'b0);
        send(16'h3C5A, 16'h0FF0, 1'b0);
        wait_done(first_valid);
        check("bp_latency", 32'(first_valid), 32'(N));
        bus.in_valid = 1'b1;
        bus.op_a     = 16'h1111;
        bus.op_b     = 16'h1111;
        bus.op_sub   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_sum", 32'(bus.sum), 32'(exp.sum));
            check("bp_cout", 32'(bus.cout), 32'(exp.cout));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_second_busy", 32'(bus.busy), 32'd1);
        wait_done(first_valid);
        check("bp_second_latency", 32'(first_valid), 32'(N));
        check("bp_second_sum", 32'(bus.sum), 32'h2222);
        release_result();

        // Reset during the second RUN cycle discards the operation.
        send(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_cout", 32'(bus.cout), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", 32'(bus.out_valid), 32'd0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 0);
        check("post_rst_sum", 32'(bus.sum), 32'h0002);

        for (int i = 0; i < 24; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom);
            run_op(ra, rb, rs, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
